// File: rtl/conv_mac_engine.sv
// rtl/conv_mac_engine.sv - KxK signed window MAC on a single multiplier between BRAM0/1 reads and BRAM2 store
module conv_mac_engine #(
    parameter int DATA_W   = 8,
    parameter int K        = 3,
    parameter int ACC_W    = 2*DATA_W + $clog2(K*K),
    parameter int BRAM_LAT = 1,
    parameter int RELU_EN  = 0
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_load_req,
    input  logic [K*K*DATA_W-1:0]   i_fm_window,
    input  logic [K*K*DATA_W-1:0]   i_k_window,
    input  logic                    i_compute_conv,
    output logic                    o_ready2compute,
    output logic                    o_conv_done,
    output logic [ACC_W-1:0]        o_result,
    output logic                    o_busy
);

    localparam int N     = K*K;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int RD_W  = (BRAM_LAT > 1) ? $clog2(BRAM_LAT) : 1;

    typedef enum logic [2:0] {S_IDLE, S_WAIT_RD, S_READY, S_MAC, S_DONE} state_t;

    state_t                    r_state;
    logic [RD_W-1:0]           r_rd_cnt;
    logic [IDX_W-1:0]          r_idx;
    logic signed [ACC_W-1:0]   r_acc;
    logic [N*DATA_W-1:0]       r_fm;
    logic [N*DATA_W-1:0]       r_k;
    logic                      r_ready;
    logic                      r_done;
    logic                      r_busy;
    logic [ACC_W-1:0]          r_result;

    logic signed [DATA_W-1:0]   w_fm_e;
    logic signed [DATA_W-1:0]   w_k_e;
    logic signed [2*DATA_W-1:0] w_prod;
    logic [ACC_W-1:0]           w_sum;

    assign w_fm_e = r_fm[r_idx*DATA_W +: DATA_W];
    assign w_k_e  = r_k[r_idx*DATA_W +: DATA_W];
    assign w_prod = w_fm_e * w_k_e;
    // Sign-extend the full-precision product; the accumulator width already covers the worst case.
    assign w_sum  = r_acc + {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_rd_cnt <= '0;
            r_idx    <= '0;
            r_acc    <= '0;
            r_fm     <= '0;
            r_k      <= '0;
            r_ready  <= 1'b0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_load_req) begin
                        r_state  <= S_WAIT_RD;
                        r_rd_cnt <= '0;
                        r_busy   <= 1'b1;
                    end
                end
                S_WAIT_RD: begin
                    if (!i_load_req) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_rd_cnt == RD_W'(BRAM_LAT-1)) begin
                        r_fm    <= i_fm_window;
                        r_k     <= i_k_window;
                        r_state <= S_READY;
                        r_ready <= 1'b1;
                    end else begin
                        r_rd_cnt <= r_rd_cnt + 1'b1;
                    end
                end
                S_READY: begin
                    if (i_compute_conv) begin
                        r_state <= S_MAC;
                        r_ready <= 1'b0;
                        r_acc   <= '0;
                        r_idx   <= '0;
                    end
                end
                S_MAC: begin
                    r_acc <= w_sum;
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == IDX_W'(N-1)) begin
                        r_result <= (RELU_EN != 0 && w_sum[ACC_W-1]) ? '0 : w_sum;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b0;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready2compute = r_ready;
    assign o_conv_done     = r_done;
    assign o_result        = r_result;
    assign o_busy          = r_busy;

endmodule

// File: tb/tb_conv_mac_engine.sv
// tb/tb_conv_mac_engine.sv - randomized self-checking bench for conv_mac_engine against a dot-product model
module tb_conv_mac_engine;

    localparam int DW    = 8;
    localparam int KK    = 3;
    localparam int N     = KK*KK;
    localparam int AW    = 2*DW + $clog2(N);
    localparam int WIN_W = N*DW;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             load_req;
    logic [WIN_W-1:0] fm_win;
    logic [WIN_W-1:0] k_win;
    logic             compute;
    logic             ready0, done0, busy0;
    logic             ready1, done1, busy1;
    logic [AW-1:0]    result0, result1;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    conv_mac_engine #(.DATA_W(DW), .K(KK), .BRAM_LAT(1), .RELU_EN(0)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_load_req(load_req),
        .i_fm_window(fm_win), .i_k_window(k_win), .i_compute_conv(compute),
        .o_ready2compute(ready0), .o_conv_done(done0), .o_result(result0), .o_busy(busy0)
    );

    conv_mac_engine #(.DATA_W(DW), .K(KK), .BRAM_LAT(1), .RELU_EN(1)) u_dut_relu (
        .i_clk(clk), .i_rst_n(rst_n), .i_load_req(load_req),
        .i_fm_window(fm_win), .i_k_window(k_win), .i_compute_conv(compute),
        .o_ready2compute(ready1), .o_conv_done(done1), .o_result(result1), .o_busy(busy1)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIN_W-1:0] pack(input int a[N]);
        logic [WIN_W-1:0] v;
        int e;
        v = '0;
        for (int i = 0; i < N; i++) begin
            e = a[i];
            v[i*DW +: DW] = e[DW-1:0];
        end
        return v;
    endfunction

    function automatic int dot(input int a[N], input int b[N]);
        int s = 0;
        for (int i = 0; i < N; i++) s += a[i] * b[i];
        return s;
    endfunction

    function automatic logic [WIN_W-1:0] rand_win();
        logic [WIN_W-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'($urandom);
        return v;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, ":ready"}, int'(ready0), 0);
        check({tag, ":done"}, int'(done0), 0);
        check({tag, ":busy"}, int'(busy0), 0);
        check({tag, ":result"}, $signed(result0), 0);
        check({tag, ":relu_result"}, $signed(result1), 0);
    endtask

    // One full controller handshake: load, capture, accept, count cycles to done, store cycle.
    task automatic run_job(input string tag, input int f[N], input int w[N], input int ready_wait);
        int exp;
        int lat;
        exp = dot(f, w);
        fm_win   = pack(f);
        k_win    = pack(w);
        load_req = 1'b1;
        tick();
        check({tag, ":ready_early"}, int'(ready0), 0);
        check({tag, ":busy_wait_rd"}, int'(busy0), 1);
        tick();
        check({tag, ":ready"}, int'(ready0), 1);
        fm_win   = rand_win();
        k_win    = rand_win();
        load_req = 1'($urandom_range(0, 1));
        for (int i = 0; i < ready_wait; i++) begin
            tick();
            check({tag, ":ready_hold"}, int'(ready0), 1);
        end
        compute = 1'b1;
        tick();
        check({tag, ":ready_after_accept"}, int'(ready0), 0);
        load_req = 1'b0;
        compute  = 1'($urandom_range(0, 1));
        lat = 0;
        while (!done0 && lat < 30) begin
            tick();
            lat++;
        end
        if (done0) done_cnt++;
        check({tag, ":latency"}, lat, N);
        check({tag, ":result"}, $signed(result0), exp);
        check({tag, ":relu_result"}, $signed(result1), (exp < 0) ? 0 : exp);
        check({tag, ":relu_done"}, int'(done1), 1);
        compute = 1'b0;
        tick();
        check({tag, ":done_pulse"}, int'(done0), 0);
        check({tag, ":store_result"}, $signed(result0), exp);
        check({tag, ":busy_after"}, int'(busy0), 0);
    endtask

    int fa[N];
    int wa[N];

    initial begin
        rst_n    = 1'b0;
        load_req = 1'b0;
        compute  = 1'b0;
        fm_win   = '0;
        k_win    = '0;
        repeat (3) tick();
        check_idle_outputs("reset");
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < N; i++) begin fa[i] = 1; wa[i] = 2; end
        run_job("ones", fa, wa, 0);

        for (int i = 0; i < N; i++) begin fa[i] = 127; wa[i] = -128; end
        run_job("extreme", fa, wa, 1);
        check("extreme_hex", int'(result0), 32'h000DC480);

        for (int i = 0; i < N; i++) begin fa[i] = i + 1; wa[i] = (i == 4) ? 1 : 0; end
        run_job("order", fa, wa, 0);

        compute = 1'b1;
        repeat (3) begin
            tick();
            check("stray_idle_busy", int'(busy0), 0);
            check("stray_idle_ready", int'(ready0), 0);
        end
        load_req = 1'b1;
        tick();
        check("stray_wait_busy", int'(busy0), 1);
        load_req = 1'b0;
        tick();
        check("drop_busy", int'(busy0), 0);
        check("drop_ready", int'(ready0), 0);
        tick();
        check("drop_ready_later", int'(ready0), 0);
        compute = 1'b0;

        for (int i = 0; i < N; i++) begin
            fa[i] = int'($urandom_range(0, 255)) - 128;
            wa[i] = int'($urandom_range(0, 255)) - 128;
        end
        fm_win   = pack(fa);
        k_win    = pack(wa);
        load_req = 1'b1;
        tick();
        tick();
        compute = 1'b1;
        tick();
        compute  = 1'b0;
        load_req = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        check_idle_outputs("rst_mid_mac");
        tick();
        rst_n = 1'b1;
        tick();
        run_job("after_rst", fa, wa, 0);

        done_cnt = 0;
        for (int j = 0; j < 5; j++) begin
            for (int i = 0; i < N; i++) begin
                fa[i] = int'($urandom_range(0, 255)) - 128;
                wa[i] = int'($urandom_range(0, 255)) - 128;
            end
            run_job($sformatf("b2b%0d", j), fa, wa, int'($urandom_range(0, 2)));
        end
        check("b2b_done_count", done_cnt, 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
